message_scroller: RTL and testbench

- Downstream consumer of the 1 Hz divided clock; scrolls a stored character message across a row of seven-segment digits.
- Runs entirely on the 50 MHz clk_in. The slow step_clk is synchronized and edge-detected into a one-cycle step tick; it is never used as a clock.
- Message contents are writable at runtime through a simple write port.
- Output feeds the board's HEX displays directly (active-low segments).

---
 rtl/msg_display_pkg.sv | 71 +++++++
 rtl/seg_decoder.sv | 11 +
 rtl/message_scroller.sv | 154 +++++++++++++++
 tb/tb_message_scroller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_display_pkg.sv
// Shared types, character codes and seven-segment glyphs for the message scroller.
package msg_display_pkg;

  typedef logic [4:0] char_code_t;

  // Named character codes; 0-9 are the decimal digits themselves
  localparam char_code_t CHAR_A     = 5'd10;
  localparam char_code_t CHAR_B     = 5'd11;
  localparam char_code_t CHAR_C     = 5'd12;
  localparam char_code_t CHAR_D     = 5'd13;
  localparam char_code_t CHAR_E     = 5'd14;
  localparam char_code_t CHAR_F     = 5'd15;
  localparam char_code_t CHAR_H     = 5'd16;
  localparam char_code_t CHAR_L     = 5'd17;
  localparam char_code_t CHAR_O     = 5'd18;
  localparam char_code_t CHAR_P     = 5'd19;
  localparam char_code_t CHAR_R     = 5'd20;
  localparam char_code_t CHAR_U     = 5'd21;
  localparam char_code_t CHAR_Y     = 5'd22;
  localparam char_code_t CHAR_DASH  = 5'd23;
  localparam char_code_t CHAR_BLANK = 5'd31;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_L     = 7'h47;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    PAUSE  = 2'd2
  } scroll_state_t;

  // Codes 24-31 (and anything unlisted) render as blank
  function automatic logic [6:0] char_to_seg(input char_code_t code);
    logic [6:0] seg;
    case (code)
      5'd0:       seg = SEG_ZERO;
      5'd1:       seg = SEG_ONE;
      5'd2:       seg = 7'h24;
      5'd3:       seg = 7'h30;
      5'd4:       seg = 7'h19;
      5'd5:       seg = 7'h12;
      5'd6:       seg = 7'h02;
      5'd7:       seg = 7'h78;
      5'd8:       seg = 7'h00;
      5'd9:       seg = 7'h10;
      CHAR_A:     seg = 7'h08;
      CHAR_B:     seg = 7'h03;
      CHAR_C:     seg = 7'h46;
      CHAR_D:     seg = 7'h21;
      CHAR_E:     seg = SEG_E;
      CHAR_F:     seg = 7'h0E;
      CHAR_H:     seg = SEG_H;
      CHAR_L:     seg = SEG_L;
      CHAR_O:     seg = 7'h23;
      CHAR_P:     seg = 7'h0C;
      CHAR_R:     seg = 7'h2F;
      CHAR_U:     seg = 7'h41;
      CHAR_Y:     seg = 7'h11;
      CHAR_DASH:  seg = SEG_DASH;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational character-code to active-low seven-segment glyph mapping.
module seg_decoder
  import msg_display_pkg::*;
(
  input  char_code_t  char_code,
  output logic [6:0]  seg
);

  assign seg = char_to_seg(char_code);

endmodule

// File: rtl/message_scroller.sv
// Scrolls a runtime-writable character message across a row of seven-segment digits.
// step_clk is only ever sampled as data; every flop runs on clk_in.
module message_scroller
  import msg_display_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int NUM_DIGITS  = 6,
  parameter int PAUSE_STEPS = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    step_clk,
  input  logic                    enable,
  input  logic                    dir,
  input  logic                    char_wr_en,
  input  logic [3:0]              char_wr_addr,
  input  char_code_t              char_wr_data,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [3:0]              pos,
  output logic                    wrap,
  output logic                    busy
);

  localparam int         CNT_W    = (PAUSE_STEPS < 2) ? 1 : $clog2(PAUSE_STEPS + 1);
  localparam logic [3:0] LAST_POS = 4'(MSG_LEN - 1);

  logic             step_s1_reg, step_s2_reg, step_s3_reg;
  logic             step_tick;
  char_code_t       msg_reg [MSG_LEN];
  scroll_state_t    state_reg, state_next;
  logic [3:0]       pos_reg, pos_next;
  logic [3:0]       pos_step;
  logic             pos_wraps;
  logic [CNT_W-1:0] pause_cnt_reg, pause_cnt_next;
  logic             wrap_reg, wrap_next;

  // Two-flop synchronizer plus a third flop for rising-edge detection
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      step_s1_reg <= 1'b0;
      step_s2_reg <= 1'b0;
      step_s3_reg <= 1'b0;
    end else begin
      step_s1_reg <= step_clk;
      step_s2_reg <= step_s1_reg;
      step_s3_reg <= step_s2_reg;
    end
  end

  assign step_tick = step_s2_reg & ~step_s3_reg;

  // Message store; an address beyond the message matches no cell and is dropped
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_reg[i] <= CHAR_BLANK;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (char_wr_en && (char_wr_addr == 4'(i))) msg_reg[i] <= char_wr_data;
      end
    end
  end

  // Neighbouring position in the current direction, with wrap detection
  always_comb begin
    pos_wraps = dir ? (pos_reg == 4'd0) : (pos_reg == LAST_POS);
    if (dir) pos_step = pos_wraps ? LAST_POS : pos_reg - 4'd1;
    else     pos_step = pos_wraps ? 4'd0     : pos_reg + 4'd1;
  end

  // Scroll FSM: enable low overrides everything; ticks move pos or count pause
  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    pause_cnt_next = pause_cnt_reg;
    wrap_next      = 1'b0;
    if (!enable) begin
      state_next     = IDLE;
      pause_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: state_next = SCROLL;
        SCROLL: begin
          if (step_tick) begin
            pos_next = pos_step;
            if (pos_wraps) begin
              wrap_next = 1'b1;
              if (PAUSE_STEPS > 0) begin
                state_next     = PAUSE;
                pause_cnt_next = '0;
              end
            end
          end
        end
        PAUSE: begin
          if (step_tick) begin
            // Leaving on the tick that would bring the count to PAUSE_STEPS
            if (pause_cnt_reg == CNT_W'(PAUSE_STEPS - 1)) begin
              state_next     = SCROLL;
              pause_cnt_next = '0;
            end else begin
              pause_cnt_next = pause_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM, position, pause counter and wrap pulse registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pos_reg       <= 4'd0;
      pause_cnt_reg <= '0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      pause_cnt_reg <= pause_cnt_next;
      wrap_reg      <= wrap_next;
    end
  end

  // One decoder per digit; leftmost digit shows msg[pos], each to its right the next index
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam logic [4:0] OFFSET = 5'(NUM_DIGITS - 1 - gi);
    logic [4:0] idx_sum;
    logic [3:0] idx;
    logic [6:0] seg_next;
    logic [6:0] seg_reg;

    assign idx_sum = {1'b0, pos_reg} + OFFSET;
    assign idx     = (idx_sum >= 5'(MSG_LEN)) ? 4'(idx_sum - 5'(MSG_LEN)) : idx_sum[3:0];

    seg_decoder u_seg_decoder (
      .char_code (msg_reg[idx]),
      .seg       (seg_next)
    );

    // Registered glyph, refreshed every cycle so writes show up one cycle later
    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) seg_reg <= SEG_BLANK;
      else        seg_reg <= seg_next;
    end

    assign seg_out[7*gi +: 7] = seg_reg;
  end

  assign pos  = pos_reg;
  assign wrap = wrap_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_message_scroller.sv
// Randomized scoreboard bench for message_scroller with a behavioural reference model.
module tb_message_scroller;

  localparam int MSG_LEN     = 16;
  localparam int NUM_DIGITS  = 6;
  localparam int PAUSE_STEPS = 2;
  localparam int SEG_W       = 7 * NUM_DIGITS;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic             step_clk = 1'b0;
  logic             enable = 1'b0;
  logic             dir = 1'b0;
  logic             char_wr_en = 1'b0;
  logic [3:0]       char_wr_addr = 4'd0;
  logic [4:0]       char_wr_data = 5'd0;
  logic [SEG_W-1:0] seg_out;
  logic [3:0]       pos;
  logic             wrap;
  logic             busy;

  message_scroller #(
    .MSG_LEN     (MSG_LEN),
    .NUM_DIGITS  (NUM_DIGITS),
    .PAUSE_STEPS (PAUSE_STEPS)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .step_clk     (step_clk),
    .enable       (enable),
    .dir          (dir),
    .char_wr_en   (char_wr_en),
    .char_wr_addr (char_wr_addr),
    .char_wr_data (char_wr_data),
    .seg_out      (seg_out),
    .pos          (pos),
    .wrap         (wrap),
    .busy         (busy)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_msg [MSG_LEN];
  int m_pos;
  int m_mode;   // 0 idle, 1 scrolling, 2 pausing
  int m_pcnt;

  function automatic logic [6:0] glyph(int c);
    case (c)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      16: return 7'h09; 17: return 7'h47;  18: return 7'h23;  19: return 7'h0C;
      20: return 7'h2F; 21: return 7'h41;  22: return 7'h11;  23: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] model_segs();
    logic [SEG_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      r[7*k +: 7] = glyph(m_msg[(m_pos + NUM_DIGITS - 1 - k) % MSG_LEN]);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 31;
    m_pos  = 0;
    m_mode = 0;
    m_pcnt = 0;
  endfunction

  typedef struct {
    int               cyc;
    logic [3:0]       pos;
    logic             wrap;
    logic [SEG_W-1:0] seg;
  } exp_t;

  exp_t sb_q[$];

  // Effect of one step; a visible move is pushed with the cycle it must appear on
  function automatic void model_tick(int issue_cyc);
    exp_t e;
    bit   wrapped;
    if (m_mode == 1) begin
      if (dir) begin
        wrapped = (m_pos == 0);
        m_pos   = (m_pos + MSG_LEN - 1) % MSG_LEN;
      end else begin
        wrapped = (m_pos == MSG_LEN - 1);
        m_pos   = (m_pos + 1) % MSG_LEN;
      end
      e.cyc  = issue_cyc + 3;
      e.pos  = 4'(m_pos);
      e.wrap = wrapped;
      e.seg  = model_segs();
      sb_q.push_back(e);
      if (wrapped && PAUSE_STEPS > 0) begin
        m_mode = 2;
        m_pcnt = 0;
      end
    end else if (m_mode == 2) begin
      m_pcnt++;
      if (m_pcnt == PAUSE_STEPS) m_mode = 1;
    end
  endfunction

  // ---------------- monitor ----------------
  bit               mon_en = 1'b0;
  logic [3:0]       last_pos = 4'd0;
  bit               seg_pending = 1'b0;
  logic [SEG_W-1:0] pend_seg;

  always @(negedge clk_in) begin
    if (!mon_en) begin
      seg_pending = 1'b0;
    end else begin
      if (seg_pending) begin
        check("seg_after_step", seg_out, pend_seg);
        check("wrap_one_cycle", wrap, 1'b0);
        seg_pending = 1'b0;
      end
      if ((pos !== last_pos) || (wrap === 1'b1)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_move", pos, last_pos);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("step_cycle", cyc, e.cyc);
          check("step_pos", pos, e.pos);
          check("step_wrap", wrap, e.wrap);
          pend_seg    = e.seg;
          seg_pending = 1'b1;
        end
      end else if ((sb_q.size() > 0) && (sb_q[0].cyc < cyc)) begin
        exp_t e;
        e = sb_q.pop_front();
        check("missed_step_pos", pos, e.pos);
      end
    end
    last_pos = pos;
  end

  // ---------------- stimulus ----------------
  task automatic do_write(int a, int d);
    @(negedge clk_in);
    char_wr_en   = 1'b1;
    char_wr_addr = 4'(a);
    char_wr_data = 5'(d);
    @(negedge clk_in);
    char_wr_en = 1'b0;
    if (a < MSG_LEN) m_msg[a] = d;
  endtask

  // Step with step_clk held high for 'hold' cycles; optional write landing on the tick edge
  task automatic do_step(int hold, bit same_wr, int wa, int wd);
    int t0;
    @(negedge clk_in);
    step_clk = 1'b1;
    t0 = cyc;
    if (same_wr && hold < 3) hold = 3;
    if (same_wr && wa < MSG_LEN) m_msg[wa] = wd;
    model_tick(t0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      if (same_wr && i == 1) begin
        char_wr_en   = 1'b1;
        char_wr_addr = 4'(wa);
        char_wr_data = 5'(wd);
      end
      if (same_wr && i == 2) char_wr_en = 1'b0;
    end
    step_clk = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic set_enable(bit v);
    @(negedge clk_in);
    enable = v;
    if (!v) begin
      m_mode = 0;
      m_pcnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic set_dir(bit d);
    @(negedge clk_in);
    dir = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();

    // Reset state, checked before any clock edge
    #1 reset = 1'b0;
    #2;
    check("reset_pos", pos, 4'd0);
    check("reset_seg", seg_out, {SEG_W{1'b1}});
    check("reset_wrap", wrap, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk_in);
    reset = 1'b1;
    mon_en = 1'b1;

    // HELLO with enable low
    do_write(0, 16); do_write(1, 14); do_write(2, 17); do_write(3, 17); do_write(4, 0);
    repeat (2) @(negedge clk_in);
    check("hello_seg", seg_out, {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F});
    check("hello_pos", pos, 4'd0);
    check("hello_busy", busy, 1'b0);

    do_step(2, 0, 0, 0);
    check("idle_tick_ignored", pos, 4'd0);

    // First scroll step with a long step_clk pulse
    set_enable(1'b1);
    check("scroll_busy", busy, 1'b1);
    do_step(100, 0, 0, 0);
    check("long_pulse_pos", pos, 4'd1);
    check("leftmost_E", seg_out[SEG_W-1 -: 7], 7'h06);

    // 15 steps to the wrap, then the pause
    for (int i = 0; i < 15; i++) do_step(1 + int'($urandom_range(2)), 0, 0, 0);
    check("wrap_pos", pos, 4'd0);
    check("pause_busy", busy, 1'b1);
    repeat (2) do_step(2, 0, 0, 0);
    check("pause_hold_pos", pos, 4'd0);
    do_step(2, 0, 0, 0);
    check("after_pause_pos", pos, 4'd1);

    // Right scroll through zero with a write landing on the wrapping tick
    set_dir(1'b1);
    do_step(2, 0, 0, 0);
    do_step(3, 1, 15, 12);
    check("right_wrap_pos", pos, 4'd15);
    check("same_edge_glyph", seg_out[SEG_W-1 -: 7], 7'h46);

    // Randomized mix of steps, writes and enable toggles
    for (int n = 0; n < 70; n++) begin
      r = int'($urandom_range(9));
      if (r <= 5) begin
        set_dir(1'($urandom_range(1)));
        if ($urandom_range(9) < 3)
          do_step(1 + int'($urandom_range(5)), 1, int'($urandom_range(15)), int'($urandom_range(31)));
        else
          do_step(1 + int'($urandom_range(5)), 0, 0, 0);
      end else if (r <= 7) begin
        do_write(int'($urandom_range(15)), int'($urandom_range(31)));
        @(negedge clk_in);
        check("write_visible", seg_out, model_segs());
      end else if (r == 8) begin
        set_enable(1'b0);
      end else begin
        set_enable(1'b1);
      end
    end
    set_enable(1'b1);
    check("random_seg", seg_out, model_segs());
    check("random_pos", pos, 4'(m_pos));

    // Drop enable while scrolling: ticks ignored, pos held
    for (int i = 0; i < 4 && m_mode != 1; i++) do_step(1, 0, 0, 0);
    set_enable(1'b0);
    check("disable_busy", busy, 1'b0);
    do_step(2, 0, 0, 0);
    do_step(3, 0, 0, 0);
    check("disable_pos_held", pos, 4'(m_pos));

    // Reset in the middle of a pause
    set_dir(1'b0);
    set_enable(1'b1);
    for (int i = 0; i < 40 && m_mode != 2; i++) do_step(1, 0, 0, 0);
    check("pre_reset_busy", busy, 1'b1);
    @(negedge clk_in);
    mon_en = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("midpause_reset_pos", pos, 4'd0);
    check("midpause_reset_seg", seg_out, {SEG_W{1'b1}});
    check("midpause_reset_wrap", wrap, 1'b0);
    check("midpause_reset_busy", busy, 1'b0);
    model_reset();
    sb_q.delete();
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    m_mode = 1;   // enable is still high, so scrolling resumes
    repeat (3) @(negedge clk_in);
    mon_en = 1'b1;
    do_write(2, 23);
    do_step(2, 0, 0, 0);
    check("post_reset_pos", pos, 4'd1);
    check("post_reset_seg", seg_out, model_segs());

    repeat (6) @(negedge clk_in);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
